// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the SR flag scheduler: FSM states, the {set,clr}
// command encoding and the rule that turns a command into the next flag value.
package sr_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Commands are formed as {set, clr}
   localparam logic [1:0] CMD_NOP = 2'b00;
   localparam logic [1:0] CMD_CLR = 2'b01;
   localparam logic [1:0] CMD_SET = 2'b10;
   localparam logic [1:0] CMD_ILL = 2'b11;

   // The illegal set+clr combination and the no-op both leave the flag alone
   function automatic logic next_flag(input logic [1:0] cmd, input logic cur);
      case (cmd)
         CMD_SET: return 1'b1;
         CMD_CLR: return 1'b0;
         CMD_NOP: return cur;
         CMD_ILL: return cur;
         default: return cur;
      endcase
   endfunction

endpackage

// File: rtl/sr_flag_scheduler_rr_arbiter.sv
// Combinational round-robin picker: searches the request vector starting at
// the pointer position, wrapping modulo NUM_REQ. The pointer register itself
// is owned by the caller.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         winner,
   output logic [$clog2(NUM_REQ)-1:0] winner_idx,
   output logic                       any_req
);

   localparam int IDX_W = $clog2(NUM_REQ);

   // First active request at or after the pointer wins
   always_comb begin
      logic [IDX_W-1:0] idx;
      winner     = '0;
      winner_idx = '0;
      any_req    = 1'b0;
      idx        = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = IDX_W'((int'(ptr) + off) % NUM_REQ);
         if (!any_req && req[idx]) begin
            any_req     = 1'b1;
            winner[idx] = 1'b1;
            winner_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/sr_flag_scheduler.sv
// Shared set/reset flag with round-robin access for NUM_REQ requesters.
// A granted command that changes the flag freezes it for HOLD_CYCLES cycles.
// Simultaneous set+clr is rejected with an err pulse alongside the grant.
// Optional macro SR_EVENT_CNT_EN adds the event_cnt transition counter.
module sr_flag_scheduler
   import sr_ctrl_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int HOLD_CYCLES = 3
`ifdef SR_EVENT_CNT_EN
   , parameter int CNT_W     = 8
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [NUM_REQ-1:0] req_set,
   input  logic [NUM_REQ-1:0] req_clr,
   output logic [NUM_REQ-1:0] grant,
   output logic [NUM_REQ-1:0] err,
   output logic               q,
   output logic               busy
`ifdef SR_EVENT_CNT_EN
   , output logic [CNT_W-1:0] event_cnt
`endif
);

   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

   state_t              state;
   logic [IDX_W-1:0]    ptr;
   logic [HOLD_W-1:0]   hold_cnt;
   logic                q_changed;

   logic [NUM_REQ-1:0]  win_onehot;
   logic [IDX_W-1:0]    win_idx;
   logic                any_req;
   logic [1:0]          win_cmd;
   logic                nxt_q;
   logic                arb_fire;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req        (req_valid),
      .ptr        (ptr),
      .winner     (win_onehot),
      .winner_idx (win_idx),
      .any_req    (any_req)
   );

   assign win_cmd  = {req_set[win_idx], req_clr[win_idx]};
   assign nxt_q    = next_flag(win_cmd, q);
   assign arb_fire = (state == IDLE) && en && any_req;

   // Arbitration, flag update and ACK/HOLD sequencing with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         hold_cnt  <= '0;
         q_changed <= 1'b0;
         q         <= 1'b0;
         grant     <= '0;
         err       <= '0;
         busy      <= 1'b0;
      end else begin
         grant <= '0;
         err   <= '0;
         case (state)
            IDLE: begin
               if (arb_fire) begin
                  grant     <= win_onehot;
                  err       <= (win_cmd == CMD_ILL) ? win_onehot : '0;
                  q         <= nxt_q;
                  q_changed <= (nxt_q != q);
                  ptr       <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                  state     <= ACK;
                  busy      <= 1'b1;
               end
            end
            ACK: begin
               if (q_changed && (HOLD_CYCLES > 0)) begin
                  hold_cnt <= HOLD_W'(HOLD_CYCLES);
                  state    <= HOLD;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            HOLD: begin
               hold_cnt <= hold_cnt - 1'b1;
               if (hold_cnt == HOLD_W'(1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef SR_EVENT_CNT_EN
   // Count every edge on which the flag takes a new value, wrapping naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         event_cnt <= '0;
      end else if (arb_fire && (nxt_q != q)) begin
         event_cnt <= event_cnt + 1'b1;
      end
   end
`else
   // Without the counter the flag and grant timing are unchanged
`endif

endmodule

// File: tb/tb_sr_flag_scheduler.sv
// Self-checking bench for sr_flag_scheduler. Expected outputs come from a
// cycle-level reference model that tracks the flag, the round-robin pointer
// and how many more edges the scheduler refuses new commands.
// Define SR_EVENT_CNT_EN to also exercise the transition counter.
module tb_sr_flag_scheduler;

   localparam int N    = 4;
   localparam int HOLD = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic [N-1:0] req_valid;
   logic [N-1:0] req_set;
   logic [N-1:0] req_clr;
   logic [N-1:0] grant;
   logic [N-1:0] err;
   logic         q;
   logic         busy;
`ifdef SR_EVENT_CNT_EN
   logic [7:0]   event_cnt;
`endif

   int checks = 0;
   int passed = 0;
   int fails  = 0;
   int cyc    = 0;

   logic [N-1:0] m_grant;
   logic [N-1:0] m_err;
   logic         m_q;
   logic         m_busy;
   int           m_ptr;
   int           m_blocked;
   int           m_events;

   sr_flag_scheduler #(
      .NUM_REQ     (N),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req_valid (req_valid),
      .req_set   (req_set),
      .req_clr   (req_clr),
      .grant     (grant),
      .err       (err),
      .q         (q),
      .busy      (busy)
`ifdef SR_EVENT_CNT_EN
      , .event_cnt (event_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_grant   = '0;
      m_err     = '0;
      m_q       = 1'b0;
      m_busy    = 1'b0;
      m_ptr     = 0;
      m_blocked = 0;
      m_events  = 0;
   endtask

   // Behavioural view: a granted value change blocks 1+HOLD edges, anything else 1
   task automatic model_edge();
      int   w;
      int   idx;
      logic nv;
      m_grant = '0;
      m_err   = '0;
      if (m_blocked > 0) begin
         m_blocked--;
      end else if (en && req_valid != '0) begin
         w = -1;
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (w < 0 && req_valid[idx]) w = idx;
         end
         m_grant[w] = 1'b1;
         m_blocked  = 1;
         if (req_set[w] && req_clr[w]) begin
            m_err[w] = 1'b1;
         end else if (req_set[w] || req_clr[w]) begin
            nv = req_set[w];
            if (nv != m_q) begin
               m_q       = nv;
               m_blocked = 1 + HOLD;
               m_events++;
            end
         end
         m_ptr = (w + 1) % N;
      end
      m_busy = (m_blocked > 0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
   endtask

   task automatic apply_reset();
      rst       = 1'b1;
      en        = 1'b1;
      req_valid = '0;
      req_set   = '0;
      req_clr   = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b0;
      en        = 1'b1;
      req_valid = '0;
      req_set   = '0;
      req_clr   = '0;
      #2;
      apply_reset();
      checks++;
      if ({grant, err, q, busy} !== '0) begin
         fails++;
         $display("[TB] FAIL reset: got g=%b e=%b q=%b b=%b want all zero", grant, err, q, busy);
      end else passed++;
   endtask

   task automatic test_single_set();
      apply_reset();
      req_valid = 4'b0100;
      req_set   = 4'b0100;
      for (int c = 0; c < 7; c++) begin
         tick();
         checks++;
         if ({grant, err, q, busy} !== {m_grant, m_err, m_q, m_busy}) begin
            fails++;
            $display("[TB] FAIL single_set c%0d: got g=%b e=%b q=%b b=%b want g=%b e=%b q=%b b=%b",
                     c, grant, err, q, busy, m_grant, m_err, m_q, m_busy);
         end else passed++;
         req_valid &= ~m_grant;
      end
   endtask

   task automatic test_round_robin();
      int order[$];
      apply_reset();
      req_valid = 4'b1111;
      req_set   = 4'b1111;
      req_clr   = 4'b0000;
      for (int c = 0; c < 14; c++) begin
         tick();
         for (int i = 0; i < N; i++) if (grant[i]) order.push_back(i);
         checks++;
         if ({grant, err, q, busy} !== {m_grant, m_err, m_q, m_busy}) begin
            fails++;
            $display("[TB] FAIL round_robin c%0d: got g=%b q=%b b=%b want g=%b q=%b b=%b",
                     c, grant, q, busy, m_grant, m_q, m_busy);
         end else passed++;
         req_valid &= ~m_grant;
      end
      checks++;
      if (order.size() != 4) begin
         fails++;
         $display("[TB] FAIL rr_count: got %0d grants want 4", order.size());
      end else begin
         passed++;
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (order[i] != i) begin
               fails++;
               $display("[TB] FAIL rr_order[%0d]: got %0d want %0d", i, order[i], i);
            end else passed++;
         end
      end
   endtask

   task automatic test_illegal();
      apply_reset();
      req_valid = 4'b0010;
      req_set   = 4'b0010;
      req_clr   = 4'b0010;
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if ({grant, err, q, busy} !== {m_grant, m_err, m_q, m_busy}) begin
            fails++;
            $display("[TB] FAIL illegal c%0d: got g=%b e=%b q=%b b=%b want g=%b e=%b q=%b b=%b",
                     c, grant, err, q, busy, m_grant, m_err, m_q, m_busy);
         end else passed++;
         req_valid &= ~m_grant;
      end
   endtask

   task automatic test_hold_spacing();
      int first_g;
      int clr_g;
      apply_reset();
      first_g   = -1;
      clr_g     = -1;
      req_valid = 4'b0001;
      req_set   = 4'b0001;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (grant[0] && first_g < 0) first_g = c;
         if (grant[1] && clr_g < 0)   clr_g   = c;
         checks++;
         if ({grant, err, q, busy} !== {m_grant, m_err, m_q, m_busy}) begin
            fails++;
            $display("[TB] FAIL hold_spacing c%0d: got g=%b q=%b b=%b want g=%b q=%b b=%b",
                     c, grant, q, busy, m_grant, m_q, m_busy);
         end else passed++;
         req_valid &= ~m_grant;
         if (c == 0) begin
            req_valid[1] = 1'b1;
            req_clr[1]   = 1'b1;
         end
      end
      checks++;
      if (first_g < 0 || clr_g < 0 || (clr_g - first_g) < 1 + HOLD + 1) begin
         fails++;
         $display("[TB] FAIL hold_gap: got set@%0d clr@%0d want gap >= %0d", first_g, clr_g, HOLD + 2);
      end else passed++;
   endtask

   task automatic test_reset_in_hold();
      apply_reset();
      req_valid = 4'b0001;
      req_set   = 4'b0001;
      tick();
      req_valid &= ~m_grant;
      req_valid[3] = 1'b1;
      req_clr[3]   = 1'b1;
      tick();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if ({grant, err, q, busy} !== '0) begin
         fails++;
         $display("[TB] FAIL reset_in_hold: got g=%b q=%b b=%b want all zero", grant, q, busy);
      end else passed++;
      @(negedge clk);
      rst = 1'b0;
      tick();
      checks++;
      if ({grant, err, q, busy} !== {m_grant, m_err, m_q, m_busy}) begin
         fails++;
         $display("[TB] FAIL after_reset_grant: got g=%b q=%b b=%b want g=%b q=%b b=%b",
                  grant, q, busy, m_grant, m_q, m_busy);
      end else passed++;
      req_valid &= ~m_grant;
      tick();
   endtask

   task automatic test_enable();
      apply_reset();
      en = 1'b0;
      for (int i = 0; i < N; i++) begin
         req_valid[i] = 1'b1;
         req_set[i]   = 1'($urandom);
         req_clr[i]   = 1'($urandom);
      end
      for (int c = 0; c < 14; c++) begin
         if (c == 10) en = 1'b1;
         tick();
         checks++;
         if ({grant, err, q, busy} !== {m_grant, m_err, m_q, m_busy}) begin
            fails++;
            $display("[TB] FAIL enable c%0d: got g=%b e=%b q=%b b=%b want g=%b e=%b q=%b b=%b",
                     c, grant, err, q, busy, m_grant, m_err, m_q, m_busy);
         end else passed++;
         req_valid &= ~m_grant;
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         en = ($urandom_range(0, 7) != 0);
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               req_valid[i] = 1'b1;
               req_set[i]   = 1'($urandom);
               req_clr[i]   = 1'($urandom);
            end
         end
         tick();
         checks++;
         if ({grant, err, q, busy} !== {m_grant, m_err, m_q, m_busy}) begin
            fails++;
            $display("[TB] FAIL random c%0d: got g=%b e=%b q=%b b=%b want g=%b e=%b q=%b b=%b",
                     c, grant, err, q, busy, m_grant, m_err, m_q, m_busy);
         end else passed++;
         req_valid &= ~m_grant;
      end
      req_valid = '0;
   endtask

`ifdef SR_EVENT_CNT_EN
   task automatic test_event_cnt();
      logic done;
      apply_reset();
      for (int a = 0; a < 300; a++) begin
         req_valid[0] = 1'b1;
         req_set[0]   = ~m_q;
         req_clr[0]   = m_q;
         done         = 1'b0;
         for (int c = 0; c < 8 && !done; c++) begin
            tick();
            if (m_grant[0]) done = 1'b1;
         end
         req_valid[0] = 1'b0;
         if (!done) begin
            checks++;
            fails++;
            $display("[TB] FAIL event_cnt_timeout: alternation %0d not granted within 8 cycles", a);
         end
      end
      checks++;
      if (event_cnt !== 8'(m_events)) begin
         fails++;
         $display("[TB] FAIL event_cnt_model: got %0d want %0d", event_cnt, m_events % 256);
      end else passed++;
      checks++;
      if (event_cnt !== 8'd44) begin
         fails++;
         $display("[TB] FAIL event_cnt_wrap: got %0d want 44", event_cnt);
      end else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_single_set();
      test_round_robin();
      test_illegal();
      test_hold_spacing();
      test_reset_in_hold();
      test_enable();
      test_random();
`ifdef SR_EVENT_CNT_EN
      test_event_cnt();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/sr_flag_scheduler.md
Name: sr_flag_scheduler

Overview:
Shares one set/reset status flag (clocked SR storage) between NUM_REQ requesters. Each requester issues set, clear or no-op commands through a valid/grant handshake. Round-robin arbitration picks the winner and applies its command to the flag. A hold-off window then blocks further commands. The illegal S=R=1 combination is resolved deterministically: the command is rejected and an error is pulsed, so the flag is never undefined.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
HOLD_CYCLES, 3, cycles the flag is frozen after a value change (0 = no hold-off)
CNT_W, 8, width of the transition counter (optional feature only)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
en  in  1  global enable; low = no new arbitration
req_valid  in  NUM_REQ  per-requester command valid, held until granted
req_set  in  NUM_REQ  per-requester set request, qualified by req_valid
req_clr  in  NUM_REQ  per-requester clear request, qualified by req_valid
grant  out  NUM_REQ  one-hot, one-cycle accept pulse
err  out  NUM_REQ  one-cycle pulse with grant when set and clr were both high
q  out  1  shared flag value
busy  out  1  high in ACK or HOLD state
event_cnt  out  CNT_W  count of q transitions (only with SR_EVENT_CNT_EN)

Behaviour:
- Reset, asynchronous: q=0, grant=0, err=0, busy=0, rr pointer=0, state=IDLE, hold counter=0, event_cnt=0. Asserting reset mid-ACK or mid-HOLD abandons the operation. No grant is issued for a request in flight; the requester keeps valid high and retries.
- All outputs are registered.
- FSM states: IDLE, ACK, HOLD.
- IDLE: if en=1 and any req_valid is set, pick winner w by round-robin. Search starts at the pointer and wraps modulo NUM_REQ. At the clock edge:
  - set grant[w]=1.
  - update q: set only -> 1; clr only -> 0; neither -> q unchanged (no-op, still granted); both -> q unchanged and err[w]=1.
  - move the pointer to (w+1) mod NUM_REQ.
  - go to ACK.
- If en=0 or no valid, stay in IDLE with all outputs unchanged.
- ACK, exactly one cycle: grant and err are high for this cycle only. No arbitration happens, so a requester that drops valid after seeing grant is never granted twice. Next state:
  - HOLD if q changed in the IDLE->ACK edge and HOLD_CYCLES>0; load hold counter = HOLD_CYCLES.
  - otherwise IDLE.
- HOLD: decrement the counter each cycle. Go to IDLE on the cycle the counter reaches 1→0, so HOLD lasts exactly HOLD_CYCLES cycles. Requests wait; nothing is granted.
- Latency: valid seen in IDLE at cycle t → grant and new q visible in cycle t+1. Minimum command spacing is 2 cycles; after a value change it is 2+HOLD_CYCLES.
- Simultaneous requests: exactly one grant per arbitration. A requester is never starved: each waits at most NUM_REQ-1 other grants.
- A write of the current value (e.g. set while q=1) is granted, does not count as a change, and causes no HOLD.
- en dropping during ACK or HOLD does not abort them. It only suppresses the next arbitration.
- busy = (state != IDLE).

Optional Feature:
SR_EVENT_CNT_EN
- Defined: event_cnt increments by 1 on every edge where q changes value, wrapping at 2^CNT_W. Cleared by rst.
- Undefined: the port and counter are absent, and q/grant timing is identical.

Decomposition:
- Package sr_ctrl_pkg holds:
  - state enum (IDLE, ACK, HOLD)
  - command encoding: CMD_NOP=2'b00, CMD_CLR=2'b01, CMD_SET=2'b10, CMD_ILL=2'b11, taken from {set,clr}
  - the function computing the next flag value from the command.
- Sub-module rr_arbiter: NUM_REQ-wide round-robin picker. Inputs: req vector and pointer. Outputs: one-hot winner, winner index and any_req. Purely combinational; the pointer register lives in sr_flag_scheduler.

Test Plan:
- Reset then requester 2 set (valid=4'b0100, set=4'b0100) → grant=4'b0100 and q=1 one cycle later; busy high for 1+3 cycles; q stays 1.
- All four valid with set, pointer=0 → grants in order 0,1,2,3, each ≥2 cycles apart. Only the first grant changes q, so no HOLD after grants 1–3.
- Requester 1 with set=clr=1 while q=0 → grant[1] and err[1] pulse together; q remains 0; no HOLD.
- Set at cycle t, then clr request from another requester at t+1 → clr granted no earlier than t+5 (ACK + 3 HOLD); q returns to 0.
- Reset asserted during HOLD → q=0 and busy=0 immediately; pending valid is granted 1 cycle after reset release.
- en=0 with valid high for 10 cycles → no grant and q unchanged. With SR_EVENT_CNT_EN: 300 set/clr alternations with CNT_W=8 → event_cnt=44 (wrap).
